// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the I/D-cache to memory cacheline arbiter and its read tracking table.
package cacheline_arb_types;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef logic [1:0] owner_mask_t;

  localparam owner_mask_t OWNER_NONE   = 2'b00;
  localparam owner_mask_t OWNER_ICACHE = 2'b01;
  localparam owner_mask_t OWNER_DCACHE = 2'b10;

  localparam logic PTR_ICACHE = 1'b0;
  localparam logic PTR_DCACHE = 1'b1;

  // line holds addr >> OFFSET_IDX, so the upper offset bits are always zero
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] line;
    owner_mask_t       owner;
  } arb_entry_t;

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] addr,
                                                input int unsigned offset_idx);
    return addr >> offset_idx;
  endfunction

endpackage

// File: rtl/cacheline_arb_table.sv
// Outstanding-read tracking table: line lookups, merge/alloc/free bookkeeping, full detection.
module cacheline_arb_table
  import cacheline_arb_types::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned OFFSET_IDX      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              resp_valid,
  input  logic [ADDR_W-1:0] resp_addr,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  owner_mask_t       alloc_owner,
  input  logic              ic_merge_en,
  input  logic              dc_merge_en,
  output logic              ic_hit,
  output logic              dc_hit,
  output logic              dc_busy,
  output logic              resp_hit,
  output owner_mask_t       resp_owner,
  output logic              full
);

  localparam int unsigned IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  arb_entry_t entries     [MAX_OUTSTANDING];
  arb_entry_t entries_nxt [MAX_OUTSTANDING];

  logic [MAX_OUTSTANDING-1:0] resp_match;
  logic [MAX_OUTSTANDING-1:0] ic_match;
  logic [MAX_OUTSTANDING-1:0] dc_match;
  logic [MAX_OUTSTANDING-1:0] dc_any;
  logic [IDX_W-1:0]           ic_idx;
  logic [IDX_W-1:0]           dc_idx;
  logic [IDX_W-1:0]           free_idx;
  logic [ADDR_W-1:0]          ic_line;
  logic [ADDR_W-1:0]          dc_line;
  logic [ADDR_W-1:0]          resp_line;
  logic [ADDR_W-1:0]          alloc_line;

  assign ic_line    = line_of(ic_addr, OFFSET_IDX);
  assign dc_line    = line_of(dc_addr, OFFSET_IDX);
  assign resp_line  = line_of(resp_addr, OFFSET_IDX);
  assign alloc_line = line_of(alloc_addr, OFFSET_IDX);

  // An entry being freed this cycle is not a merge target, but still blocks writes.
  always_comb begin
    resp_match = '0;
    ic_match   = '0;
    dc_match   = '0;
    dc_any     = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      resp_match[i] = resp_valid && entries[i].valid && (entries[i].line == resp_line);
      ic_match[i]   = entries[i].valid && (entries[i].line == ic_line) && !resp_match[i];
      dc_any[i]     = entries[i].valid && (entries[i].line == dc_line);
      dc_match[i]   = dc_any[i] && !resp_match[i];
    end
  end

  assign ic_hit   = |ic_match;
  assign dc_hit   = |dc_match;
  assign dc_busy  = |dc_any;
  assign resp_hit = |resp_match;

  always_comb begin
    resp_owner = OWNER_NONE;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (resp_match[i]) resp_owner = resp_owner | entries[i].owner;
    end
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    ic_idx   = '0;
    dc_idx   = '0;
    free_idx = '0;
    full     = 1'b1;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (ic_match[i]) ic_idx = IDX_W'(i);
      if (dc_match[i]) dc_idx = IDX_W'(i);
      if (!entries[i].valid) begin
        free_idx = IDX_W'(i);
        full     = 1'b0;
      end
    end
  end

  always_comb begin
    entries_nxt = entries;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (resp_match[i]) entries_nxt[i] = '0;
    end
    if (ic_merge_en) entries_nxt[ic_idx].owner = entries_nxt[ic_idx].owner | OWNER_ICACHE;
    if (dc_merge_en) entries_nxt[dc_idx].owner = entries_nxt[dc_idx].owner | OWNER_DCACHE;
    if (alloc_en) begin
      entries_nxt[free_idx].valid = 1'b1;
      entries_nxt[free_idx].line  = alloc_line;
      entries_nxt[free_idx].owner = alloc_owner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) entries[i] <= '0;
    end else begin
      entries <= entries_nxt;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares the memory cacheline port between icache and dcache with read merging and RAW blocking.
// Define CACHELINE_ARB_RR_EN for round-robin arbitration; otherwise dcache has fixed priority.
module cacheline_arbiter
  import cacheline_arb_types::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned OFFSET_IDX      = 5
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_read,
  input  logic              icache_write,
  input  logic [LINE_W-1:0] icache_wdata,
  output logic              icache_ready,
  output logic [ADDR_W-1:0] icache_raddr,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_rvalid,

  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_ready,
  output logic [ADDR_W-1:0] dcache_raddr,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_rvalid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_raddr,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  logic        ic_rd;
  logic        dc_rd;
  logic        dc_wr;
  logic        t_ic_hit;
  logic        t_dc_hit;
  logic        t_dc_busy;
  logic        t_resp_hit;
  owner_mask_t t_resp_owner;
  logic        t_full;
  logic        ic_merge;
  logic        dc_merge;
  logic        ic_elig;
  logic        dc_elig;
  logic        gnt_ic;
  logic        gnt_dc;
  logic        alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  owner_mask_t alloc_owner;

  // The icache port is read-only.
  logic unused_icache;
  assign unused_icache = ^{icache_write, icache_wdata};

  assign ic_rd = icache_read;
  assign dc_wr = dcache_write;
  assign dc_rd = dcache_read & ~dcache_write;

  cacheline_arb_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OFFSET_IDX      (OFFSET_IDX)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .ic_addr     (icache_addr),
    .dc_addr     (dcache_addr),
    .resp_valid  (mem_rvalid),
    .resp_addr   (mem_raddr),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .alloc_owner (alloc_owner),
    .ic_merge_en (ic_merge),
    .dc_merge_en (dc_merge),
    .ic_hit      (t_ic_hit),
    .dc_hit      (t_dc_hit),
    .dc_busy     (t_dc_busy),
    .resp_hit    (t_resp_hit),
    .resp_owner  (t_resp_owner),
    .full        (t_full)
  );

  // Merged reads never touch the memory port, so they bypass arbitration entirely.
  assign ic_merge = rst & ic_rd & t_ic_hit;
  assign dc_merge = rst & dc_rd & t_dc_hit;

  assign ic_elig = rst & ic_rd & ~t_ic_hit & ~t_full;
  assign dc_elig = rst & ((dc_rd & ~t_dc_hit & ~t_full) | (dc_wr & ~t_dc_busy));

`ifdef CACHELINE_ARB_RR_EN
  logic rr_ptr;

  assign gnt_dc = dc_elig & (~ic_elig | (rr_ptr == PTR_DCACHE));
  assign gnt_ic = ic_elig & ~gnt_dc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= PTR_ICACHE;
    end else if (mem_ready && (((rr_ptr == PTR_ICACHE) && gnt_ic) ||
                               ((rr_ptr == PTR_DCACHE) && gnt_dc))) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`else
  assign gnt_dc = dc_elig;
  assign gnt_ic = ic_elig & ~dc_elig;
`endif

  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    if (gnt_ic) begin
      mem_addr = icache_addr;
      mem_read = 1'b1;
    end else if (gnt_dc) begin
      mem_addr  = dcache_addr;
      mem_read  = dc_rd;
      mem_write = dc_wr;
      mem_wdata = dcache_wdata;
    end
  end

  assign icache_ready = ic_merge | (gnt_ic & mem_ready);
  assign dcache_ready = dc_merge | (gnt_dc & mem_ready);

  assign alloc_en    = mem_ready & (gnt_ic | (gnt_dc & dc_rd));
  assign alloc_addr  = gnt_dc ? dcache_addr : icache_addr;
  assign alloc_owner = gnt_dc ? OWNER_DCACHE : OWNER_ICACHE;

  assign icache_raddr  = mem_raddr;
  assign icache_rdata  = mem_rdata;
  assign dcache_raddr  = mem_raddr;
  assign dcache_rdata  = mem_rdata;
  assign icache_rvalid = t_resp_hit & t_resp_owner[0];
  assign dcache_rvalid = t_resp_hit & t_resp_owner[1];

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed scenarios plus random traffic against a table-level model.
module tb_cacheline_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  icache_addr, dcache_addr, mem_addr, mem_raddr;
  logic         icache_read, icache_write, dcache_read, dcache_write;
  logic [255:0] icache_wdata, dcache_wdata, mem_wdata, mem_rdata;
  logic         icache_ready, dcache_ready, icache_rvalid, dcache_rvalid;
  logic [31:0]  icache_raddr, dcache_raddr;
  logic [255:0] icache_rdata, dcache_rdata;
  logic         mem_read, mem_write, mem_ready, mem_rvalid;

  always #5 clk = ~clk;

  cacheline_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_read(icache_read), .icache_write(icache_write),
    .icache_wdata(icache_wdata), .icache_ready(icache_ready), .icache_raddr(icache_raddr),
    .icache_rdata(icache_rdata), .icache_rvalid(icache_rvalid),
    .dcache_addr(dcache_addr), .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_wdata(dcache_wdata), .dcache_ready(dcache_ready), .dcache_raddr(dcache_raddr),
    .dcache_rdata(dcache_rdata), .dcache_rvalid(dcache_rvalid),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  int vectors = 0;
  int miscompares = 0;

  // model: outstanding line table and round-robin owner
  bit          m_valid [4];
  logic [26:0] m_line  [4];
  logic [1:0]  m_own   [4];
  bit          m_ptr;

  bit e_ic_ready, e_dc_ready, e_ic_rv, e_dc_rv, e_mem_read, e_mem_write;
  logic [31:0] e_mem_addr;

  logic         s_ic_ready, s_dc_ready, s_ic_rv, s_dc_rv, s_mem_read, s_mem_write;
  logic [31:0]  s_mem_addr;
  logic [255:0] s_ic_rdata;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int fi, fr, ic_mi, dc_mi;
    bit full, wr_blk, ic_el, dc_el, g_ic, g_dc, dc_rd;
    s_ic_ready = icache_ready;  s_dc_ready = dcache_ready;
    s_ic_rv    = icache_rvalid; s_dc_rv    = dcache_rvalid;
    s_mem_read = mem_read;      s_mem_write = mem_write;
    s_mem_addr = mem_addr;      s_ic_rdata = icache_rdata;
    fi = -1; fr = -1; ic_mi = -1; dc_mi = -1;
    full = 1'b1; wr_blk = 1'b0; g_ic = 1'b0; g_dc = 1'b0;
    dc_rd = dcache_read && !dcache_write;
    if (!rst) begin
      for (int j = 0; j < 4; j++) begin m_valid[j] = 0; m_own[j] = 0; end
      m_ptr = 0;
      {e_ic_ready, e_dc_ready, e_ic_rv, e_dc_rv, e_mem_read, e_mem_write} = '0;
      e_mem_addr = '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (fi < 0 && mem_rvalid && m_valid[j] && m_line[j] == mem_raddr[31:5]) fi = j;
        if (!m_valid[j]) begin full = 0; if (fr < 0) fr = j; end
      end
      for (int j = 0; j < 4; j++) begin
        if (m_valid[j] && j != fi) begin
          if (ic_mi < 0 && icache_read && m_line[j] == icache_addr[31:5]) ic_mi = j;
          if (dc_mi < 0 && dc_rd && m_line[j] == dcache_addr[31:5]) dc_mi = j;
        end
        if (m_valid[j] && dcache_write && m_line[j] == dcache_addr[31:5]) wr_blk = 1;
      end
      e_ic_rv = (fi >= 0) ? m_own[fi][0] : 1'b0;
      e_dc_rv = (fi >= 0) ? m_own[fi][1] : 1'b0;
      ic_el = icache_read && ic_mi < 0 && !full;
      dc_el = (dc_rd && dc_mi < 0 && !full) || (dcache_write && !wr_blk);
`ifdef CACHELINE_ARB_RR_EN
      if (ic_el && dc_el) begin g_ic = (m_ptr == 0); g_dc = !g_ic; end
      else begin g_ic = ic_el; g_dc = dc_el; end
`else
      g_dc = dc_el;
      g_ic = ic_el && !dc_el;
`endif
      e_mem_read  = g_ic || (g_dc && dc_rd);
      e_mem_write = g_dc && dcache_write;
      e_mem_addr  = g_dc ? dcache_addr : icache_addr;
      e_ic_ready  = (ic_mi >= 0) || (g_ic && mem_ready);
      e_dc_ready  = (dc_mi >= 0) || (g_dc && mem_ready);
    end
    chk("mem_read", mem_read, e_mem_read);
    chk("mem_write", mem_write, e_mem_write);
    if (e_mem_read || e_mem_write) chk("mem_addr", mem_addr, e_mem_addr);
    if (e_mem_write) chk("mem_wdata", mem_wdata, dcache_wdata);
    chk("icache_ready", icache_ready, e_ic_ready);
    chk("dcache_ready", dcache_ready, e_dc_ready);
    chk("icache_rvalid", icache_rvalid, e_ic_rv);
    chk("dcache_rvalid", dcache_rvalid, e_dc_rv);
    if (e_ic_rv || e_dc_rv) begin
      chk("rdata_bcast", dcache_rdata, mem_rdata);
      chk("raddr_bcast", icache_raddr, mem_raddr);
    end
    if (rst) begin
      if (fi >= 0) begin m_valid[fi] = 0; m_own[fi] = 0; end
      if (ic_mi >= 0) m_own[ic_mi][0] = 1'b1;
      if (dc_mi >= 0) m_own[dc_mi][1] = 1'b1;
      if (e_mem_read && mem_ready && fr >= 0) begin
        m_valid[fr] = 1;
        m_line[fr]  = e_mem_addr[31:5];
        m_own[fr]   = g_ic ? 2'b01 : 2'b10;
      end
      if (mem_ready && ((m_ptr == 0 && g_ic) || (m_ptr == 1 && g_dc))) m_ptr = !m_ptr;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icache_read = 0; icache_write = 0; dcache_read = 0; dcache_write = 0;
    mem_ready = 0; mem_rvalid = 0;
  endtask

  task automatic issue(input bit dc, input logic [31:0] a);
    if (dc) begin dcache_read = 1; dcache_addr = a; end
    else begin icache_read = 1; icache_addr = a; end
    mem_ready = 1;
    cycle();
    chk(dc ? "issue_dc_ready" : "issue_ic_ready", dc ? s_dc_ready : s_ic_ready, 1'b1);
    dcache_read = 0; icache_read = 0; mem_ready = 0;
  endtask

  task automatic respond(input logic [31:0] a, input logic [255:0] d);
    mem_rvalid = 1; mem_raddr = a; mem_rdata = d;
    cycle();
    mem_rvalid = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0000_7000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
  endfunction

  bit           ic_act, dc_act, dc_w;
  logic [31:0]  ic_a, dc_a;
  logic [255:0] dc_d;
  logic [31:0]  pq_addr [$];
  int           pq_due  [$];

  initial begin
    rst = 0; idle();
    icache_addr = 0; dcache_addr = 0; icache_wdata = 0; dcache_wdata = 0;
    mem_raddr = 0; mem_rdata = 0;

    // requests held during reset must not leak through
    icache_read = 1; dcache_write = 1; mem_ready = 1;
    repeat (3) cycle();
    chk("rst_ic_ready", s_ic_ready, 1'b0);
    chk("rst_mem_write", s_mem_write, 1'b0);
    idle();
    rst = 1;
    cycle();

    // single icache read, response 10 cycles later
    icache_read = 1; icache_addr = 32'h0000_1040; mem_ready = 1;
    cycle();
    chk("t1_ic_ready", s_ic_ready, 1'b1);
    chk("t1_mem_addr", s_mem_addr, 32'h0000_1040);
    idle();
    repeat (9) cycle();
    respond(32'h0000_1040, {8{32'hA5A5_1040}});
    chk("t1_ic_rvalid", s_ic_rv, 1'b1);
    chk("t1_dc_rvalid", s_dc_rv, 1'b0);
    chk("t1_rdata", s_ic_rdata, {8{32'hA5A5_1040}});
    icache_read = 1; icache_addr = 32'h0000_1040; mem_ready = 1;
    cycle();
    chk("t1_table_empty", s_mem_read, 1'b1);
    idle();
    respond(32'h0000_1040, '0);

    // simultaneous reads to different lines
    icache_read = 1; icache_addr = 32'h0000_0100;
    dcache_read = 1; dcache_addr = 32'h0000_0200; mem_ready = 1;
    cycle();
`ifdef CACHELINE_ARB_RR_EN
    chk("t2_first_ic", s_ic_ready, 1'b1);
    chk("t2_first_addr", s_mem_addr, 32'h0000_0100);
    icache_read = 0;
    cycle();
    chk("t2_second_dc", s_dc_ready, 1'b1);
`else
    chk("t2_first_dc", s_dc_ready, 1'b1);
    chk("t2_first_addr", s_mem_addr, 32'h0000_0200);
    dcache_read = 0;
    cycle();
    chk("t2_second_ic", s_ic_ready, 1'b1);
`endif
    idle();
    respond(32'h0000_0100, '0);
    respond(32'h0000_0200, '0);

    // merge of an icache read into an in-flight dcache read
    issue(1, 32'h0000_2000);
    icache_read = 1; icache_addr = 32'h0000_2010; mem_ready = 1;
    cycle();
    chk("t3_merge_ready", s_ic_ready, 1'b1);
    chk("t3_no_mem_read", s_mem_read, 1'b0);
    idle();
    respond(32'h0000_2000, {8{32'h2000_BEEF}});
    chk("t3_ic_rvalid", s_ic_rv, 1'b1);
    chk("t3_dc_rvalid", s_dc_rv, 1'b1);

    // full table stalls a fifth read; unrelated write still goes
    issue(0, 32'h0000_4000);
    issue(1, 32'h0000_4040);
    issue(0, 32'h0000_4080);
    issue(1, 32'h0000_40C0);
    icache_read = 1; icache_addr = 32'h0000_4100;
    dcache_write = 1; dcache_addr = 32'h0000_5000; dcache_wdata = {8{32'h5555_0000}};
    mem_ready = 1;
    cycle();
    chk("t4_full_ic_ready", s_ic_ready, 1'b0);
    chk("t4_write_ready", s_dc_ready, 1'b1);
    chk("t4_mem_write", s_mem_write, 1'b1);
    dcache_write = 0;
    respond(32'h0000_4000, '0);
    chk("t4_stall_in_rvalid", s_ic_ready, 1'b0);
    cycle();
    chk("t4_fifth_issues", s_ic_ready, 1'b1);
    chk("t4_fifth_addr", s_mem_addr, 32'h0000_4100);
    idle();
    respond(32'h0000_4040, '0);
    respond(32'h0000_4080, '0);
    respond(32'h0000_40C0, '0);
    respond(32'h0000_4100, '0);

    // write held off by a pending read of the same line
    issue(1, 32'h0000_3000);
    dcache_write = 1; dcache_addr = 32'h0000_3000; dcache_wdata = {8{32'h3333_3333}};
    mem_ready = 1;
    cycle();
    chk("t5_blocked", s_dc_ready, 1'b0);
    chk("t5_no_write", s_mem_write, 1'b0);
    respond(32'h0000_3000, '0);
    chk("t5_blocked_rvalid", s_dc_ready, 1'b0);
    cycle();
    chk("t5_accepted", s_dc_ready, 1'b1);
    chk("t5_mem_write", s_mem_write, 1'b1);
    idle();

    // reset with reads outstanding; late responses are dropped
    issue(0, 32'h0000_6000);
    issue(1, 32'h0000_6040);
    icache_read = 1; icache_addr = 32'h0000_6080; mem_ready = 1;
    rst = 0;
    cycle();
    chk("t6_rst_ready", s_ic_ready, 1'b0);
    chk("t6_rst_mem_read", s_mem_read, 1'b0);
    rst = 1; idle();
    cycle();
    respond(32'h0000_6000, '0);
    chk("t6_drop_ic", s_ic_rv, 1'b0);
    respond(32'h0000_6040, '0);
    chk("t6_drop_dc", s_dc_rv, 1'b0);

    // random traffic
    ic_act = 0; dc_act = 0; dc_w = 0; ic_a = 0; dc_a = 0; dc_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ic_act && $urandom_range(0, 2) == 0) begin ic_act = 1; ic_a = rand_addr(); end
      if (!dc_act && $urandom_range(0, 2) == 0) begin
        dc_act = 1; dc_a = rand_addr(); dc_w = ($urandom_range(0, 2) == 0);
        dc_d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      icache_read  = ic_act; icache_addr = ic_a;
      icache_write = 1'($urandom_range(0, 1));
      icache_wdata = {8{$urandom}};
      dcache_read  = dc_act && !dc_w;
      dcache_write = dc_act && dc_w;
      dcache_addr  = dc_a; dcache_wdata = dc_d;
      mem_ready  = ($urandom_range(0, 3) != 0);
      mem_rvalid = 0;
      mem_rdata  = {8{$urandom}};
      if (pq_addr.size() > 0 && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, pq_addr.size() - 1);
        if (pq_due[k] <= c) begin
          mem_rvalid = 1;
          mem_raddr  = pq_addr[k] | 32'($urandom_range(0, 31));
          pq_addr.delete(k);
          pq_due.delete(k);
        end
      end else if ($urandom_range(0, 40) == 0) begin
        mem_rvalid = 1;
        mem_raddr  = 32'hF000_0000 | 32'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 599) == 0) rst = 0;
      cycle();
      rst = 1;
      if (e_ic_ready) ic_act = 0;
      if (e_dc_ready) dc_act = 0;
      if (e_mem_read && mem_ready) begin
        pq_addr.push_back({e_mem_addr[31:5], 5'b0});
        pq_due.push_back(c + int'($urandom_range(1, 12)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
